qspi_bus_arbiter: RTL and testbench
===================================

Name: qspi_bus_arbiter

Overview:
- Round-robin arbiter sharing the single quad-SPI pin group (sclk, sio0..3, ce[2:0]) between up to NUM_REQ masters, e.g. instruction fetch, data port and a DMA/boot loader.
- Drives the active-low chip enables and a grant vector; the SoC's pin mux uses the grant vector to select which master's sclk/sio/oe reach the pads.
- Enforces a minimum CE-high gap between transactions (tCPH).
- Signals masters to yield after a maximum hold time, which covers the PSRAM tCEM refresh limit.

Parameters:
- NUM_REQ, 3: number of requesting masters (2..4).
- CPH_CYCLES, 2: minimum number of clk cycles all ce_n stay high between two grants (>=1).
- MAX_HOLD, 64: grant cycles before yield asserts (>=1).
- HOLD_W, 8: hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NUM_REQ: per-master bus request. Held high for the whole transaction; dropped to release the bus.
- req_sel, input, 2*NUM_REQ: per-master chip select (0..2), field i at [2i+1:2i]. Must be stable while req[i] is high.
- gnt, output, NUM_REQ: one-hot grant, registered.
- gnt_idx, output, 2: binary index of the current grantee, for the pad mux. Valid while busy.
- busy, output, 1: bus granted (state GRANT).
- ce_n, output, 3: active-low chip enables to the pads.
- yield, output, 1: current grant has been held for >= MAX_HOLD cycles.
- err_sel, output, 1: sticky flag; a request with req_sel==3 was seen.

Behaviour:
Reset (async, immediate):
- gnt=0, gnt_idx=0, busy=0, ce_n=3'b111, yield=0, err_sel=0.
- State IDLE, round-robin pointer=0, hold counter=0.
- Asserting reset mid-transaction releases CE combinationally-fast. There is no graceful end; masters are reset by the same rst_n.

State machine: IDLE, GRANT, GAP.

Eligibility:
- eligible[i] = req[i] && req_sel[i] != 3.
- Any req[i] with req_sel[i]==3 sets err_sel. err_sel clears only on reset.
- An ineligible request is never granted.

IDLE:
- At each edge, if any eligible[i], pick the first eligible index at or after the pointer (circular) and go to GRANT.
- On that same edge: gnt[k]=1, gnt_idx=k, busy=1, ce_n[req_sel[k]]=0 (latched), hold counter=0.
- Latency: a request sampled at edge e is granted at the outputs after e (1 cycle).

GRANT:
- Chip select is latched at grant and ignored afterwards.
- The hold counter increments each cycle and saturates at MAX_HOLD.
- yield=1 when the counter reaches MAX_HOLD. It stays high until release.
- Requests from other masters never preempt. yield is advisory; the grantee must drop req at a safe boundary.
- Release: at the first edge where req[k]==0, gnt=0, busy=0, ce_n=3'b111, yield=0, pointer=(k+1) mod NUM_REQ. Go to GAP with the gap counter loaded.

GAP:
- Lasts exactly CPH_CYCLES cycles with ce_n all high and gnt=0.
- On the edge ending the last GAP cycle, arbitration runs as in IDLE. With a pending eligible request, go straight to GRANT; otherwise go to IDLE.
- Requests raised during GAP are not lost, only delayed.

Minimum CE-high time:
- Back-to-back transactions give exactly CPH_CYCLES cycles of ce_n=111.

Withdrawal:
- A master may drop req before it is granted. Arbitration samples req only at the arbitration edge.

Single requester:
- A master that re-requests after release is re-granted after the gap, even though the pointer has moved past it.

Simultaneous events:
- A release edge is never also an arbitration edge. The GAP state is mandatory.

Invariants (assert in the bench):
- gnt is one-hot or zero.
- At most one ce_n bit is low.
- ce_n != 111 iff busy.

Test Plan:
- Reset, then req=001, req_sel0=1 at edge 1 → after edge 1: gnt=001, ce_n=101, busy=1. Drop req at edge 10 → ce_n=111 after edge 10, and after CPH_CYCLES=2 cycles the state is IDLE.
- req=111 held continuously, each master releasing after 4 grant cycles → grant order 0,1,2,0. Each gap is exactly 2 cycles of ce_n=111, and gnt_idx tracks the grant.
- Single master holds req for 70 cycles → yield rises after 64 grant cycles, no preemption occurs even with req1 pending, and yield=0 on release.
- req_sel1=3 with req=010 → never granted, err_sel=1 sticky. Then req0 with sel 2 → ce_n=011.
- rst_n pulled low mid-GRANT, asynchronously between clock edges → ce_n=111, gnt=0, yield=0 before the next clk edge. After release, req1 is granted first (pointer=0, req0 idle).
- req2 raised during the GAP following a grant to master 0 → granted on the edge ending the gap, with no extra IDLE cycle.

Source files
------------

// File: rtl/qspi_bus_arbiter_if.sv
// Bundle of the request/grant and pad-control signals between the quad-SPI masters and the arbiter.
// The arbiter connects through the slave modport; requesters and benches use the master modport.
interface qspi_bus_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]   req;
   logic [2*NUM_REQ-1:0] req_sel;
   logic [NUM_REQ-1:0]   gnt;
   logic [1:0]           gnt_idx;
   logic                 busy;
   logic [2:0]           ce_n;
   logic                 yield;
   logic                 err_sel;

   modport master (
      output req, req_sel,
      input  gnt, gnt_idx, busy, ce_n, yield, err_sel
   );

   modport slave (
      input  req, req_sel,
      output gnt, gnt_idx, busy, ce_n, yield, err_sel
   );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner of the shared quad-SPI pin group: grants one master at a time,
// enforces a CE-high gap between owners and flags long holds with yield.
module qspi_bus_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int CPH_CYCLES = 2,
   parameter int MAX_HOLD   = 64,
   parameter int HOLD_W     = 8
) (
   input logic              clk,
   input logic              rst_n,
   qspi_bus_arbiter_if.slave bus
);

   localparam int GAP_W = (CPH_CYCLES > 1) ? $clog2(CPH_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t              r_state;
   logic [1:0]          r_ptr;
   logic [HOLD_W-1:0]   r_hold;
   logic [GAP_W-1:0]    r_gap;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [1:0]          r_gnt_idx;
   logic                r_busy;
   logic [2:0]          r_ce_n;
   logic                r_yield;
   logic                r_err_sel;

   logic [NUM_REQ-1:0]  w_eligible;
   logic [1:0]          w_sel [NUM_REQ];
   logic                w_bad_sel;
   logic                w_pick_valid;
   logic [1:0]          w_pick_idx;
   logic [1:0]          w_cand;
   logic                w_arb_edge;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_eligible   = '0;
      w_bad_sel    = 1'b0;
      w_pick_valid = 1'b0;
      w_pick_idx   = 2'd0;
      w_cand       = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel[i]      = bus.req_sel[2*i +: 2];
         w_eligible[i] = bus.req[i] && (w_sel[i] != 2'd3);
         w_bad_sel     = w_bad_sel | (bus.req[i] && (w_sel[i] == 2'd3));
      end
      // Scan from the far end back to the pointer so the nearest eligible index wins.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         w_cand = 2'((int'(r_ptr) + j) % NUM_REQ);
         if (w_eligible[w_cand]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   assign w_arb_edge = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == '0));

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_hold    <= '0;
         r_gap     <= '0;
         r_gnt     <= '0;
         r_gnt_idx <= 2'd0;
         r_busy    <= 1'b0;
         r_ce_n    <= 3'b111;
         r_yield   <= 1'b0;
         r_err_sel <= 1'b0;
      end else begin
         r_err_sel <= r_err_sel | w_bad_sel;

         case (r_state)
            S_GRANT: begin
               if (!bus.req[r_gnt_idx]) begin
                  r_state <= S_GAP;
                  r_gap   <= GAP_W'(CPH_CYCLES - 1);
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ce_n  <= 3'b111;
                  r_yield <= 1'b0;
                  r_ptr   <= (r_gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : r_gnt_idx + 2'd1;
               end else begin
                  if (r_hold != HOLD_W'(MAX_HOLD)) r_hold <= r_hold + 1'b1;
                  if (r_hold >= HOLD_W'(MAX_HOLD - 1)) r_yield <= 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap != '0) r_gap <= r_gap - 1'b1;
            end
            default: ;
         endcase

         // The release edge is only in S_GRANT, so it can never coincide with arbitration.
         if (w_arb_edge) begin
            if (w_pick_valid) begin
               r_state   <= S_GRANT;
               r_gnt     <= NUM_REQ'(1) << w_pick_idx;
               r_gnt_idx <= w_pick_idx;
               r_busy    <= 1'b1;
               r_ce_n    <= ~(3'b001 << w_sel[w_pick_idx]);
               r_hold    <= '0;
               r_yield   <= 1'b0;
            end else begin
               r_state <= S_IDLE;
            end
         end
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.gnt_idx = r_gnt_idx;
   assign bus.busy    = r_busy;
   assign bus.ce_n    = r_ce_n;
   assign bus.yield   = r_yield;
   assign bus.err_sel = r_err_sel;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: an owner/gap/pointer model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_qspi_bus_arbiter;
   localparam int NUM_REQ  = 3;
   localparam int CPH      = 2;
   localparam int MAX_HOLD = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qspi_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   qspi_bus_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .CPH_CYCLES(CPH),
      .MAX_HOLD  (MAX_HOLD),
      .HOLD_W    (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the bus (-1 = nobody), CE-high cycles still owed, rotation start, grant age.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_gap   = 0;
   int m_sel   = 0;
   bit m_err   = 1'b0;

   function automatic int sel_of(input int i);
      return int'(bus.req_sel[2*i +: 2]);
   endfunction

   function automatic void model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_gap = 0; m_sel = 0; m_err = 1'b0;
   endfunction

   function automatic void model_step();
      for (int i = 0; i < NUM_REQ; i++)
         if (bus.req[i] && sel_of(i) == 3) m_err = 1'b1;
      if (m_owner >= 0) begin
         if (!bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
            m_gap   = CPH;
         end else if (m_hold < MAX_HOLD) begin
            m_hold++;
         end
      end else begin
         if (m_gap > 0) m_gap--;
         if (m_gap == 0) begin
            for (int j = 0; j < NUM_REQ; j++) begin
               int c;
               c = (m_ptr + j) % NUM_REQ;
               if (bus.req[c] && sel_of(c) != 3) begin
                  m_owner = c; m_sel = sel_of(c); m_hold = 0;
                  break;
               end
            end
         end
      end
   endfunction

   task automatic compare();
      bit busy_e;
      busy_e = (m_owner >= 0);
      check("model_gnt",   32'(bus.gnt),  busy_e ? (1 << m_owner) : 0);
      check("model_busy",  32'(bus.busy), 32'(busy_e));
      check("model_ce_n",  32'(bus.ce_n), busy_e ? ((~(1 << m_sel)) & 7) : 7);
      check("model_yield", 32'(bus.yield), 32'(busy_e && m_hold >= MAX_HOLD));
      check("model_err",   32'(bus.err_sel), 32'(m_err));
      if (busy_e) check("model_gnt_idx", 32'(bus.gnt_idx), m_owner);
      check("inv_gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      check("inv_ce_one_low",  32'($countones(~bus.ce_n) <= 1), 1);
      check("inv_ce_busy",     32'((bus.ce_n != 3'b111) == bus.busy), 1);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      compare();
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit v, input logic [1:0] sel);
      bus.req_sel[2*i +: 2] = sel;
      bus.req[i]            = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      bus.req = '0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_order [4] = '{0, 1, 2, 0};
      int g;
      bus.req     = '0;
      bus.req_sel = '0;
      rst_n       = 1'b0;
      tick(2);
      rst_n = 1'b1;
      check("rst_gnt",   32'(bus.gnt), 0);
      check("rst_busy",  32'(bus.busy), 0);
      check("rst_ce_n",  32'(bus.ce_n), 7);
      check("rst_yield", 32'(bus.yield), 0);
      check("rst_err",   32'(bus.err_sel), 0);

      // Single grant with chip select 1, released after 9 grant cycles.
      set_req(0, 1'b1, 2'd1);
      tick();
      check("t1_gnt",  32'(bus.gnt), 1);
      check("t1_ce_n", 32'(bus.ce_n), 3'b101);
      check("t1_busy", 32'(bus.busy), 1);
      tick(8);
      bus.req[0] = 1'b0;
      tick();
      check("t1_rel_ce_n", 32'(bus.ce_n), 7);
      check("t1_rel_busy", 32'(bus.busy), 0);
      tick(2);
      check("t1_idle_busy", 32'(bus.busy), 0);

      // Round robin with all three masters requesting.
      do_reset();
      bus.req_sel = {2'd2, 2'd1, 2'd0};
      bus.req     = 3'b111;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("rr_busy",    32'(bus.busy), 1);
         check("rr_gnt_idx", 32'(bus.gnt_idx), exp_order[k]);
         check("rr_gnt",     32'(bus.gnt), 1 << exp_order[k]);
         tick(3);
         bus.req[exp_order[k]] = 1'b0;
         tick();
         if (k < 3) begin
            bus.req[exp_order[k]] = 1'b1;
            g = 0;
            for (int c = 0; c < 20 && !bus.busy; c++) begin
               if (bus.ce_n == 3'b111) g++;
               tick();
            end
            check("rr_gap_len", g, CPH);
         end
      end
      bus.req = '0;
      tick(4);

      // Long hold: yield after MAX_HOLD grant cycles, no preemption by master 1.
      do_reset();
      set_req(0, 1'b1, 2'd0);
      set_req(1, 1'b1, 2'd1);
      tick();
      for (int n = 1; n <= 70; n++) begin
         if (n == 64) check("hold_yield_64", 32'(bus.yield), 0);
         if (n == 65) check("hold_yield_65", 32'(bus.yield), 1);
         if (n == 70) check("hold_no_preempt", 32'(bus.gnt), 1);
         tick();
      end
      bus.req[0] = 1'b0;
      tick();
      check("hold_rel_yield", 32'(bus.yield), 0);
      check("hold_rel_busy",  32'(bus.busy), 0);
      tick(2);
      check("hold_next_gnt",  32'(bus.gnt), 3'b010);
      check("hold_next_ce_n", 32'(bus.ce_n), 3'b101);
      bus.req = '0;
      tick(4);

      // Invalid chip select is never granted and latches err_sel.
      do_reset();
      set_req(1, 1'b1, 2'd3);
      tick(3);
      check("sel3_busy", 32'(bus.busy), 0);
      check("sel3_err",  32'(bus.err_sel), 1);
      set_req(0, 1'b1, 2'd2);
      tick();
      check("sel3_gnt0", 32'(bus.gnt), 1);
      check("sel3_ce_n", 32'(bus.ce_n), 3'b011);
      bus.req = '0;
      tick(4);
      check("sel3_sticky", 32'(bus.err_sel), 1);

      // Asynchronous reset in the middle of a yielding grant.
      do_reset();
      set_req(0, 1'b1, 2'd0);
      tick();
      check("arst_busy", 32'(bus.busy), 1);
      tick(66);
      check("arst_pre_yield", 32'(bus.yield), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ce_n",  32'(bus.ce_n), 7);
      check("arst_gnt",   32'(bus.gnt), 0);
      check("arst_yield", 32'(bus.yield), 0);
      check("arst_busy0", 32'(bus.busy), 0);
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1, 1'b1, 2'd1);
      tick();
      check("arst_gnt1",  32'(bus.gnt), 3'b010);
      check("arst_idx1",  32'(bus.gnt_idx), 1);
      check("arst_ce1",   32'(bus.ce_n), 3'b101);
      bus.req = '0;
      tick(4);

      // Request raised during the gap is granted on the edge ending the gap.
      do_reset();
      set_req(0, 1'b1, 2'd0);
      tick();
      check("gap_gnt0", 32'(bus.gnt_idx), 0);
      tick(2);
      bus.req[0] = 1'b0;
      tick();
      check("gap_c1_busy", 32'(bus.busy), 0);
      set_req(2, 1'b1, 2'd2);
      tick();
      check("gap_c2_ce_n", 32'(bus.ce_n), 7);
      tick();
      check("gap_gnt2", 32'(bus.gnt), 3'b100);
      check("gap_ce2",  32'(bus.ce_n), 3'b011);
      bus.req = '0;
      tick(4);

      // Randomized traffic, alternating short-hold and long-hold phases.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int lim;
         lim = ((cyc / 500) % 2 == 1) ? 90 : 5;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
               if ($urandom_range(0, lim) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
            end
         end
         tick();
      end
      bus.req = '0;
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
